// File: rtl/hls_mem_pkg.sv
// hls_mem_pkg: shared widths and read-pipeline stage type for the HLS memory responder
package hls_mem_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int RD_LAT_MAX = 4;
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_stage_t;
endpackage

// File: rtl/hls_mem_rd_pipe.sv
// hls_mem_rd_pipe: RD_LAT-deep read return pipeline; output holds the last returned word
module hls_mem_rd_pipe
  import hls_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);
  localparam int LAT = (RD_LAT < 1) ? 1 : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  rd_stage_t         stg [LAT];
  logic [DATA_W-1:0] hold;
  // shift issued reads toward the output; reset flushes anything in flight
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
      hold <= '0;
    end else begin
      stg[0] <= {in_valid, in_data};
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
      if (stg[LAT-1].valid) hold <= stg[LAT-1].data;
    end
  end
  assign q_valid = stg[LAT-1].valid;
  assign q       = q_valid ? stg[LAT-1].data : hold;
endmodule

// File: rtl/hls_mem_responder.sv
// hls_mem_responder: ap_memory-style word store with preload, error flag and optional stats (HLS_MEM_RESP_STATS_EN)
module hls_mem_responder
  import hls_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] address0,
  input  logic              ce0,
  input  logic              we0,
  input  logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] q0,
  output logic              q0_valid,
  input  logic              init_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              err,
  input  logic              clear_stats,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              a_ok, i_ok, rd_acc, wr_acc, pre_acc, err_set;
  logic [DATA_W-1:0] rd_data;
  assign a_ok    = address0 < ADDR_W'(DEPTH);
  assign i_ok    = init_addr < ADDR_W'(DEPTH);
  assign rd_acc  = ce0 & ~we0;
  assign wr_acc  = ce0 & we0;
  assign pre_acc = init_en & ~ce0 & i_ok;
  assign err_set = (ce0 & ~a_ok) | (init_en & (ce0 | ~i_ok));
  assign rd_data = a_ok ? mem[address0[IW-1:0]] : '0;
  // storage is deliberately outside the reset domain so preloaded contents survive reset
  always_ff @(posedge ap_clk) begin
    if (wr_acc && a_ok) mem[address0[IW-1:0]] <= d0;
    else if (pre_acc) mem[init_addr[IW-1:0]] <= init_data;
  end
  hls_mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (rd_acc),
    .in_data  (rd_data),
    .q        (q0),
    .q_valid  (q0_valid)
  );
  // sticky error, cleared only by clear_stats or reset
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) err <= 1'b0;
    else if (clear_stats) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`ifdef HLS_MEM_RESP_STATS_EN
  // saturating access counters; a clear in the same cycle wins over the access
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (clear_stats) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_acc && rd_count != '1) rd_count <= rd_count + 32'd1;
      if (wr_acc && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_hls_mem_responder.sv
// tb_hls_mem_responder: randomized and directed checks of three latency variants against a history model
module tb_hls_mem_responder;
  localparam int DEPTH = 256;
  localparam int NL    = 3;
  localparam int HN    = 4096;
`ifdef HLS_MEM_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ce0 = 1'b0, we0 = 1'b0, init_en = 1'b0, clear_stats = 1'b0;
  logic [31:0] address0 = '0, d0 = '0, init_addr = '0, init_data = '0;
  logic [31:0] q0_a [NL];
  logic        q0v_a [NL];
  logic        err_a [NL];
  logic [31:0] rdc_a [NL];
  logic [31:0] wrc_a [NL];
  for (genvar g = 0; g < NL; g++) begin : g_dut
    hls_mem_responder #(.DEPTH(DEPTH), .RD_LAT(g + 1)) dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .address0    (address0),
      .ce0         (ce0),
      .we0         (we0),
      .d0          (d0),
      .q0          (q0_a[g]),
      .q0_valid    (q0v_a[g]),
      .init_en     (init_en),
      .init_addr   (init_addr),
      .init_data   (init_data),
      .err         (err_a[g]),
      .clear_stats (clear_stats),
      .rd_count    (rdc_a[g]),
      .wr_count    (wrc_a[g])
    );
  end
  always #5 ap_clk = ~ap_clk;
  logic [31:0] mem_m [DEPTH];
  bit          iss_v [HN];
  logic [31:0] iss_d [HN];
  logic [31:0] hold_m [NL];
  int          cyc = 0;
  bit          err_m = 1'b0;
  logic [31:0] rd_m = '0, wr_m = '0;
  int          checks = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic verify();
    for (int l = 0; l < NL; l++) begin
      int idx = cyc - l;
      bit ev = (idx >= 0) && iss_v[idx];
      if (ev) hold_m[l] = iss_d[idx];
      check($sformatf("q0_valid_L%0d", l + 1), 32'(q0v_a[l]), 32'(ev));
      check($sformatf("q0_L%0d", l + 1), q0_a[l], hold_m[l]);
      check($sformatf("err_L%0d", l + 1), 32'(err_a[l]), 32'(err_m));
      check($sformatf("rd_count_L%0d", l + 1), rdc_a[l], STATS ? rd_m : 32'd0);
      check($sformatf("wr_count_L%0d", l + 1), wrc_a[l], STATS ? wr_m : 32'd0);
    end
  endtask
  task automatic step(input bit c, input bit w, input logic [31:0] a, input logic [31:0] dd,
                      input bit ie, input logic [31:0] ia, input logic [31:0] id, input bit cs);
    bit ok;
    ce0 = c; we0 = w; address0 = a; d0 = dd;
    init_en = ie; init_addr = ia; init_data = id; clear_stats = cs;
    @(posedge ap_clk);
    cyc++;
    if (c) begin
      ok = a < DEPTH;
      if (w) begin
        if (ok) mem_m[a[7:0]] = dd;
        if (wr_m != '1) wr_m++;
      end else begin
        iss_v[cyc] = 1'b1;
        iss_d[cyc] = ok ? mem_m[a[7:0]] : 32'd0;
        if (rd_m != '1) rd_m++;
      end
      if (!ok) err_m = 1'b1;
    end
    if (ie) begin
      if (c || ia >= DEPTH) err_m = 1'b1;
      else mem_m[ia[7:0]] = id;
    end
    if (cs) begin
      err_m = 1'b0;
      rd_m = '0;
      wr_m = '0;
    end
    #1 verify();
  endtask
  task automatic rd(input logic [31:0] a);
    step(1, 0, a, $urandom, 0, 0, 0, 0);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    ce0 = 0; we0 = 0; init_en = 0; clear_stats = 0;
    #2 ap_rst_n = 1'b0;
    for (int i = 0; i < HN; i++) iss_v[i] = 1'b0;
    for (int l = 0; l < NL; l++) hold_m[l] = '0;
    err_m = 1'b0; rd_m = '0; wr_m = '0;
    #1 verify();
    repeat (2) @(posedge ap_clk);
    cyc += 2;
    #1 verify();
    @(negedge ap_clk) ap_rst_n = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(0, $urandom, $urandom, $urandom, 1, i, (i == 5) ? 32'hDEAD_BEEF : $urandom, 0);
    rd(5);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 7, 32'h1234, 0, 0, 0, 0);
    rd(7);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) rd(i);
    idle(4);
    rd(300);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    step(1, 0, 9, 0, 1, 9, 32'hCAFE_0009, 0);
    idle(3);
    rd(9);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 256, 32'h5555_AAAA, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h1, 0);
    rd(255);
    rd(256);
    rd(0);
    idle(3);
    step(1, 0, 3, 0, 0, 0, 0, 1);
    idle(3);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 40));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), a, $urandom,
           $urandom_range(0, 15) == 0, 32'($urandom_range(0, DEPTH + 20)), $urandom,
           $urandom_range(0, 40) == 0);
    end
    idle(4);
    rd(1);
    rd(2);
    do_reset();
    idle(5);
    rd(5);
    rd(7);
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
